// File: rtl/alu_exec_unit.sv
// 16-bit ALU execution unit with a valid/ready handshake and AND/ADD/SUB/SLL/SRL operations.
// Define ALU_EXEC_BARREL_EN to make shifts single-cycle; otherwise shifts take one bit per cycle.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_ctrl,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        zero,
  output logic        carry,
  output logic        illegal
);

  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;

`ifdef ALU_EXEC_BARREL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        illegal_q, illegal_d;

  logic        fin_s;
  logic [15:0] fin_res_s;
  logic        fin_carry_s;
  logic        fin_ill_s;
  logic [16:0] add_s;
  logic [16:0] sub_s;
  logic [3:0]  amt_s;

`ifndef ALU_EXEC_BARREL_EN
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic [15:0] acc_nxt_s;
`endif

  assign add_s = {1'b0, op_a} + {1'b0, op_b};
  // Bit 16 of the widened difference is the unsigned borrow (op_a < op_b).
  assign sub_s = {1'b0, op_a} - {1'b0, op_b};
  assign amt_s = op_b[3:0];

  // Next-state and result computation.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    illegal_d   = illegal_q;
    fin_s       = 1'b0;
    fin_res_s   = 16'h0000;
    fin_carry_s = 1'b0;
    fin_ill_s   = 1'b0;
`ifndef ALU_EXEC_BARREL_EN
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    acc_nxt_s   = left_q ? {acc_q[14:0], 1'b0} : {1'b0, acc_q[15:1]};
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (alu_ctrl)
            OP_AND: begin
              fin_s     = 1'b1;
              fin_res_s = op_a & op_b;
            end
            OP_ADD: begin
              fin_s       = 1'b1;
              fin_res_s   = add_s[15:0];
              fin_carry_s = add_s[16];
            end
            OP_SUB: begin
              fin_s       = 1'b1;
              fin_res_s   = sub_s[15:0];
              fin_carry_s = sub_s[16];
            end
            OP_SLL, OP_SRL: begin
`ifdef ALU_EXEC_BARREL_EN
              fin_s     = 1'b1;
              fin_res_s = (alu_ctrl == OP_SLL) ? (op_a << amt_s) : (op_a >> amt_s);
`else
              if (amt_s == 4'd0) begin
                fin_s     = 1'b1;
                fin_res_s = op_a;
              end else begin
                state_d = SHIFT;
                acc_d   = op_a;
                cnt_d   = amt_s;
                left_d  = (alu_ctrl == OP_SLL);
              end
`endif
            end
            default: begin
              fin_s     = 1'b1;
              fin_ill_s = 1'b1;
            end
          endcase
        end else begin
          state_d = IDLE;
        end

        if (fin_s) begin
          state_d   = DONE;
          result_d  = fin_res_s;
          zero_d    = (fin_res_s == 16'h0000);
          carry_d   = fin_carry_s;
          illegal_d = fin_ill_s;
        end else begin
          result_d = result_q;
        end
      end
`ifndef ALU_EXEC_BARREL_EN
      SHIFT: begin
        acc_d = acc_nxt_s;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = DONE;
          result_d  = acc_nxt_s;
          zero_d    = (acc_nxt_s == 16'h0000);
          carry_d   = 1'b0;
          illegal_d = 1'b0;
        end else begin
          state_d = SHIFT;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= 16'h0000;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifndef ALU_EXEC_BARREL_EN
      acc_q     <= 16'h0000;
      cnt_q     <= 4'd0;
      left_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
`ifndef ALU_EXEC_BARREL_EN
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctrl;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        carry;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .carry(carry), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation definitions.
  task automatic model(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic cy, output logic ill, output int wait_edges);
    longint la, lb, lr;
    int n;
    la = longint'(a);
    lb = longint'(b);
    n  = int'(b % 16'd16);
    cy = 1'b0; ill = 1'b0; lr = 0; wait_edges = 0;
    case (c)
      3'd1: lr = longint'(a & b);
      3'd2: begin lr = (la + lb) % 65536; cy = (la + lb) > 65535; end
      3'd3: begin lr = (la - lb + 65536) % 65536; cy = (la < lb); end
      3'd4: lr = (la * (64'sd1 << n)) % 65536;
      3'd5: lr = la / (64'sd1 << n);
      default: begin lr = 0; ill = 1'b1; end
    endcase
`ifndef ALU_EXEC_BARREL_EN
    if (c == 3'd4 || c == 3'd5) wait_edges = n;
`endif
    res = lr[15:0];
  endtask

  task automatic do_op(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] er;
    logic ec, ei;
    int ek, k;
    model(c, a, b, er, ec, ei, ek);
    k = 0;
    while (in_ready !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctrl = 3'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
    @(negedge clk);
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'($urandom); alu_ctrl = 3'($urandom); op_a = 16'($urandom);
      @(negedge clk);
      k++;
    end
    chk("latency", k, ek);
    chk("result", {16'd0, result}, {16'd0, er});
    chk("zero", {31'd0, zero}, {31'd0, (er == 16'h0000)});
    chk("carry", {31'd0, carry}, {31'd0, ec});
    chk("illegal", {31'd0, illegal}, {31'd0, ei});
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); alu_ctrl = 3'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", {16'd0, result}, {16'd0, er});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    chk("drain_result", {16'd0, result}, {16'd0, er});
    chk("drain_illegal", {31'd0, illegal}, {31'd0, ei});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 3'd0; op_a = 16'h0000; op_b = 16'h0000;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {29'd0, zero, carry, illegal}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_op(3'b010, 16'hFFFF, 16'h0001, 1);   // ADD wrap: 0, zero, carry
    do_op(3'b011, 16'h0003, 16'h0005, 0);   // SUB borrow
    do_op(3'b001, 16'hF0F0, 16'h0FF0, 2);
    do_op(3'b100, 16'h0001, 16'h0004, 1);
    do_op(3'b101, 16'h8000, 16'h000F, 0);
    do_op(3'b100, 16'h1234, 16'hFFF0, 0);   // amount 0, upper bits ignored
    do_op(3'b111, 16'h1234, 16'h5678, 1);
    do_op(3'b010, 16'h0001, 16'h0002, 0);   // legal op clears illegal
    do_op(3'b000, 16'hAAAA, 16'h5555, 0);
    do_op(3'b110, 16'hAAAA, 16'h5555, 0);
    do_op(3'b011, 16'h4321, 16'h4321, 10);  // long hold with toggling inputs

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  c;
      logic [15:0] a, b;
      c = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 5 == 0) b = a;
      do_op(c, a, b, $urandom_range(0, 3));
    end

    // Abort a long shift with reset.
    alu_ctrl = 3'b100; op_a = 16'h0001; op_b = 16'h000A; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_flags", {29'd0, zero, carry, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    do_op(3'b010, 16'h1000, 16'h2000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset; no other clocks or resets exist.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 alu_ctrl  input  3  operation code: 001 AND, 010 ADD, 011 SUB, 100 SLL, 101 SRL; 000/110/111 illegal.
REQ-007 op_a  input  16  first operand; shift source for SLL/SRL.
REQ-008 op_b  input  16  second operand; op_b[3:0] is the shift amount for SLL/SRL, op_b[15:4] ignored for shifts.
REQ-009 out_valid  output  1  result, zero, carry and illegal are valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  16  operation result.
REQ-012 zero  output  1  result == 16'h0000.
REQ-013 carry  output  1  ADD carry-out of bit 15; SUB borrow (op_a < op_b, unsigned); 0 for all other operations.
REQ-014 illegal  output  1  the completed request carried an illegal alu_ctrl.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 Accept occurs on a rising edge with state IDLE and in_valid high; alu_ctrl, op_a and op_b SHALL be captured at that edge, and later input changes SHALL have no effect on that operation.
REQ-017 AND/ADD/SUB: at the accept edge, IDLE->DONE with the registered result; out_valid is high after that edge (1-cycle latency).
REQ-018 ADD/SUB: result SHALL be modulo 2^16 (no saturation).
REQ-019 SLL/SRL with amount 0: IDLE->DONE at the accept edge with result = op_a.
REQ-020 SLL/SRL with amount n>0: IDLE->SHIFT at the accept edge, with the shift accumulator = op_a and the counter = n.
REQ-021 SHIFT state: each edge shifts the accumulator by one bit (SLL left, SRL logical right, zero fill) and decrements the counter; on the edge where the counter is 1, the FSM enters DONE; out_valid is high n cycles after accept.
REQ-022 Illegal alu_ctrl: IDLE->DONE at the accept edge with result=0, zero=1, carry=0, illegal=1.
REQ-023 DONE state: out_valid=1; result and all flags are held stable while out_ready is low, for any number of cycles.
REQ-024 DONE with out_ready high at an edge: ->IDLE; out_valid falls after that edge; result and flags keep their last values.
REQ-025 in_ready SHALL be low in SHIFT and DONE; in_valid is ignored there; there is no back-to-back accept on the edge that completes DONE; maximum throughput is one operation per 2 cycles.
REQ-026 in_valid and in_ready SHALL be mutually independent of out_ready combinationally; all outputs are registered or decoded from state only.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, result=0, zero=0, carry=0, illegal=0, out_valid=0, the counter to 0 and the accumulator to 0; in_ready=1 while in reset.
REQ-028 Reset asserted in SHIFT or DONE SHALL abort the operation with no result delivered; the first accept is possible on the first edge after rst_n rises.

Configuration
REQ-029 Macro ALU_EXEC_BARREL_EN defined: SLL/SRL SHALL complete in a single cycle like AND/ADD/SUB (IDLE->DONE at accept), the SHIFT state and the counter are absent, and in_ready behaviour is unchanged.
REQ-030 Macro ALU_EXEC_BARREL_EN undefined: the iterative shift of REQ-020/021 applies.
REQ-031 Results SHALL be bit-identical in both configurations; only the latency differs.

Verification
REQ-032 ADD op_a=16'hFFFF, op_b=16'h0001 -> one cycle later out_valid=1, result=16'h0000, zero=1, carry=1.
REQ-033 SUB op_a=16'h0003, op_b=16'h0005 -> result=16'hFFFE, carry=1, zero=0; AND 16'hF0F0 & 16'h0FF0 -> result=16'h00F0.
REQ-034 SLL op_a=16'h0001, op_b=16'h0004 (iterative) -> out_valid 4 cycles after accept, result=16'h0010; SRL op_a=16'h8000 by 15 -> 16'h0001 after 15 cycles; the barrel build gives both in 1 cycle.
REQ-035 alu_ctrl=3'b111 -> 1 cycle later illegal=1, result=0, zero=1; the next legal op clears illegal.
REQ-036 out_ready held low 10 cycles in DONE while inputs toggle -> result stable and in_ready=0; out_ready pulse -> IDLE next cycle.
REQ-037 rst_n pulsed low mid-SHIFT (SLL by 10, cycle 3) -> immediately out_valid=0 and result=0, no result delivered, and a new request is accepted after release.
